// File: rtl/tdm_demux4.sv
// tdm_demux4 - receive side of a 4-slot address-driven TDM link.
// Tracks the slot address from sync marks, rebuilds the parallel frame,
// flywheels over a limited number of missing sync marks and flags errors.
module tdm_demux4 #(
   parameter int N_KAN    = 4,
   parameter int ADR_W    = 2,
   parameter int MAX_MISS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inf_ul,
   input  logic               en_ul,
   input  logic               sync_ul,
   output logic [N_KAN-1:0]   inf_izl,
   output logic [ADR_W-1:0]   adr_izl,
   output logic               valid_izl,
   output logic               lock_izl,
   output logic               err_izl
);

   // Miss counter must be able to hold MAX_MISS itself.
   localparam int MW = (MAX_MISS < 1) ? 1 : $clog2(MAX_MISS + 1);
   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(N_KAN - 1);
   localparam logic [MW:0]      MISS_LIM = (MW + 1)'(MAX_MISS);

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [N_KAN-1:0]   part_q, part_d;
   logic [N_KAN-1:0]   inf_q, inf_d;
   logic [MW-1:0]      miss_q, miss_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               lock_q, lock_d;
   logic [MW:0]        miss_inc_s;

   assign miss_inc_s = {1'b0, miss_q} + {{MW{1'b0}}, 1'b1};

   // Next-state logic: slot tracking, frame assembly, sync/flywheel decisions.
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      part_d  = part_q;
      inf_d   = inf_q;
      miss_d  = miss_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (en_ul) begin
         case (state_q)
            ST_HUNT: begin
               if (sync_ul) begin
                  part_d    = {N_KAN{1'b0}};
                  part_d[0] = inf_ul;
                  adr_d     = ADR_W'(1);
                  miss_d    = {MW{1'b0}};
                  state_d   = ST_LOCK;
               end else begin
                  // Unaligned bit: discarded, keep hunting at slot 0.
                  adr_d = {ADR_W{1'b0}};
               end
            end
            ST_LOCK: begin
               if (adr_q != {ADR_W{1'b0}}) begin
                  if (sync_ul) begin
                     // Sync mark in mid-frame: drop the partial frame and realign.
                     err_d     = 1'b1;
                     part_d    = {N_KAN{1'b0}};
                     part_d[0] = inf_ul;
                     adr_d     = ADR_W'(1);
                     miss_d    = {MW{1'b0}};
                  end else begin
                     part_d[adr_q] = inf_ul;
                     if (adr_q == LAST_ADR) begin
                        inf_d   = part_d;
                        valid_d = 1'b1;
                        adr_d   = {ADR_W{1'b0}};
                     end else begin
                        adr_d = adr_q + ADR_W'(1);
                     end
                  end
               end else begin
                  if (sync_ul) begin
                     part_d    = {N_KAN{1'b0}};
                     part_d[0] = inf_ul;
                     adr_d     = ADR_W'(1);
                     miss_d    = {MW{1'b0}};
                  end else if (miss_inc_s >= MISS_LIM) begin
                     // Too many missing marks in a row: alignment is gone.
                     err_d   = 1'b1;
                     state_d = ST_HUNT;
                     adr_d   = {ADR_W{1'b0}};
                     miss_d  = {MW{1'b0}};
                  end else begin
                     // Flywheel: assume slot 0 and keep going.
                     miss_d    = miss_inc_s[MW-1:0];
                     part_d    = {N_KAN{1'b0}};
                     part_d[0] = inf_ul;
                     adr_d     = ADR_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               adr_d   = {ADR_W{1'b0}};
               miss_d  = {MW{1'b0}};
            end
         endcase
      end else begin
         // Gap cycle: hold everything, pulses fall back to 0.
         state_d = state_q;
      end
      lock_d = (state_d == ST_LOCK);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HUNT;
         adr_q   <= {ADR_W{1'b0}};
         part_q  <= {N_KAN{1'b0}};
         inf_q   <= {N_KAN{1'b0}};
         miss_q  <= {MW{1'b0}};
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         part_q  <= part_d;
         inf_q   <= inf_d;
         miss_q  <= miss_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         lock_q  <= lock_d;
      end
   end

   assign inf_izl   = inf_q;
   assign adr_izl   = adr_q;
   assign valid_izl = valid_q;
   assign lock_izl  = lock_q;
   assign err_izl   = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a frame scoreboard.
module tb_tdm_demux4;

   logic       clk;
   logic       rst;
   logic       inf_ul;
   logic       en_ul;
   logic       sync_ul;
   logic [3:0] inf_izl;
   logic [1:0] adr_izl;
   logic       valid_izl;
   logic       lock_izl;
   logic       err_izl;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] exp_q[$];

   tdm_demux4 #(.N_KAN(4), .ADR_W(2), .MAX_MISS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .inf_ul    (inf_ul),
      .en_ul     (en_ul),
      .sync_ul   (sync_ul),
      .inf_izl   (inf_izl),
      .adr_izl   (adr_izl),
      .valid_izl (valid_izl),
      .lock_izl  (lock_izl),
      .err_izl   (err_izl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One clock with given inputs; outputs are settled 1 time unit after the edge.
   task automatic cyc(input logic en, input logic d, input logic s);
      en_ul   = en;
      inf_ul  = d;
      sync_ul = s;
      @(posedge clk);
      #1;
      en_ul   = 1'b0;
      inf_ul  = 1'b0;
      sync_ul = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard: every valid pulse must match the next expected frame.
   always @(negedge clk) begin
      if (valid_izl) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL sb_unexpected_valid observed=%0h expected=none", inf_izl);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            assert (inf_izl === e) else begin
               n_bad++;
               $error("FAIL sb_frame observed=%0h expected=%0h", inf_izl, e);
            end
         end
      end
      if (valid_izl || err_izl) begin
         n_cmp++;
         assert (!(valid_izl && err_izl)) else begin
            n_bad++;
            $error("FAIL valid_err_both observed=1 expected=0");
         end
      end
   end

   initial begin
      rst = 1'b1; en_ul = 1'b0; inf_ul = 1'b0; sync_ul = 1'b0;
      // T1 reset
      @(posedge clk); @(posedge clk); #1;
      chk("t1_inf", 32'(inf_izl), 32'h0);
      chk("t1_adr", 32'(adr_izl), 32'h0);
      chk("t1_valid", 32'(valid_izl), 32'h0);
      chk("t1_lock", 32'(lock_izl), 32'h0);
      chk("t1_err", 32'(err_izl), 32'h0);
      rst = 1'b0;

      // T2 back-to-back frame 0,1,0,1
      cyc(1'b1, 1'b0, 1'b1);
      chk("t2_lock", 32'(lock_izl), 32'h1);
      chk("t2_adr1", 32'(adr_izl), 32'h1);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t2_adr2", 32'(adr_izl), 32'h2);
      cyc(1'b1, 1'b0, 1'b0);
      chk("t2_adr3", 32'(adr_izl), 32'h3);
      chk("t2_noval", 32'(valid_izl), 32'h0);
      exp_q.push_back(4'b1010);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t2_valid", 32'(valid_izl), 32'h1);
      chk("t2_inf", 32'(inf_izl), 32'hA);
      chk("t2_adr0", 32'(adr_izl), 32'h0);
      idle(1);
      chk("t2_pulse", 32'(valid_izl), 32'h0);

      // T3 same frame with 3 idle cycles between strobes
      cyc(1'b1, 1'b0, 1'b1); idle(3);
      chk("t3_adr1", 32'(adr_izl), 32'h1);
      cyc(1'b1, 1'b1, 1'b0); idle(3);
      chk("t3_adr2", 32'(adr_izl), 32'h2);
      cyc(1'b1, 1'b0, 1'b0); idle(3);
      chk("t3_adr3", 32'(adr_izl), 32'h3);
      chk("t3_noval", 32'(valid_izl), 32'h0);
      exp_q.push_back(4'b1010);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t3_valid", 32'(valid_izl), 32'h1);
      idle(3);
      chk("t3_adr0", 32'(adr_izl), 32'h0);
      chk("t3_inf", 32'(inf_izl), 32'hA);

      // T4 sync again at slot 2 -> resync, then bits 1,1,0
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t4_err", 32'(err_izl), 32'h1);
      chk("t4_noval", 32'(valid_izl), 32'h0);
      chk("t4_adr", 32'(adr_izl), 32'h1);
      chk("t4_hold", 32'(inf_izl), 32'hA);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t4_errpulse", 32'(err_izl), 32'h0);
      cyc(1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'h7);
      cyc(1'b1, 1'b0, 1'b0);
      chk("t4_inf", 32'(inf_izl), 32'h7);

      // T5 sync frame C, flywheel frame 3, then lock lost
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'hC);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t5_infC", 32'(inf_izl), 32'hC);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t5_fly_lock", 32'(lock_izl), 32'h1);
      chk("t5_fly_err", 32'(err_izl), 32'h0);
      chk("t5_fly_adr", 32'(adr_izl), 32'h1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      exp_q.push_back(4'h3);
      cyc(1'b1, 1'b0, 1'b0);
      chk("t5_inf3", 32'(inf_izl), 32'h3);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t5_err", 32'(err_izl), 32'h1);
      chk("t5_unlock", 32'(lock_izl), 32'h0);
      chk("t5_adr", 32'(adr_izl), 32'h0);
      chk("t5_hold", 32'(inf_izl), 32'h3);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t5_hunt_adr", 32'(adr_izl), 32'h0);
      chk("t5_hunt_lock", 32'(lock_izl), 32'h0);

      // T6 reset mid-frame, unsynced slots ignored
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t6_adr3", 32'(adr_izl), 32'h3);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      chk("t6_inf", 32'(inf_izl), 32'h0);
      chk("t6_adr", 32'(adr_izl), 32'h0);
      chk("t6_lock", 32'(lock_izl), 32'h0);
      chk("t6_valid", 32'(valid_izl), 32'h0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t6_ign_adr", 32'(adr_izl), 32'h0);
      chk("t6_ign_lock", 32'(lock_izl), 32'h0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t6_relock", 32'(lock_izl), 32'h1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      exp_q.push_back(4'hD);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t6_inf", 32'(inf_izl), 32'hD);

      idle(3);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
